// File: rtl/collision_pkg.sv
// Shared constants and FSM state type for the sprite collision detector.
package collision_pkg;

  // Default raster geometry, shared with the sprite mask renderers
  localparam int DEF_ACTIVE_H = 1280;
  localparam int DEF_ACTIVE_V = 720;

  // Widths of the raster position counters
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ACCUM,
    EVAL,
    HIT
  } state_e;

endpackage

// File: rtl/sprite_collision_detector_sat_counter.sv
// Saturating up-counter: clear to zero, load a 0/1 seed, or increment
// without ever wrapping past all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_CNT = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear dominates load, load dominates increment
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = W'(inc);
    end else if (inc && (count_q != MAX_CNT)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sprite_collision_detector.sv
// Counts player/obstacle mask overlap pixels over one active frame and
// latches a collision flag when the frame count reaches THRESHOLD.
module sprite_collision_detector
  import collision_pkg::*;
#(
  parameter int ACTIVE_H  = DEF_ACTIVE_H,
  parameter int ACTIVE_V  = DEF_ACTIVE_V,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 16
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [VCNT_W-1:0] vcount_in,
  input  logic              player_draw_in,
  input  logic              obstacle_draw_in,
  input  logic              enable_in,
  input  logic              clear_in,
  output logic              collision_out,
  output logic              hit_pulse_out,
  output logic              frame_done_out,
  output logic [CNT_W-1:0]  overlap_count_out
);

  localparam logic [HCNT_W-1:0] H_LIM = HCNT_W'(ACTIVE_H);
  localparam logic [VCNT_W-1:0] V_LIM = VCNT_W'(ACTIVE_V);
  localparam logic [CNT_W-1:0]  TH    = CNT_W'(THRESHOLD);

  state_e state_q, state_d;

  logic start_p0_d, start_p0_q;
  logic end_p0_d, end_p0_q;
  logic ovl_p0_d, ovl_p0_q;

  logic acc_clear, acc_load;
  logic [CNT_W-1:0] acc;
  logic hit_now;

  logic collision_d, collision_q;
  logic hit_pulse_d, hit_pulse_q;
  logic frame_done_d, frame_done_q;
  logic [CNT_W-1:0] count_d, count_q;

  // Decode raster markers and gated overlap for the current pixel
  always_comb begin
    start_p0_d = (hcount_in == '0) && (vcount_in == '0);
    end_p0_d   = (hcount_in == '0) && (vcount_in == V_LIM);
    ovl_p0_d   = player_draw_in && obstacle_draw_in &&
                 (hcount_in < H_LIM) && (vcount_in < V_LIM);
  end

  // Stage p0: registered markers (control) and overlap bit (data)
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      start_p0_q <= 1'b0;
      end_p0_q   <= 1'b0;
    end else begin
      start_p0_q <= start_p0_d;
      end_p0_q   <= end_p0_d;
    end
    ovl_p0_q <= ovl_p0_d;
  end

  // Overlap accumulator; ARMED/ACCUM seed it on a start marker
  sat_counter #(
    .W(CNT_W)
  ) u_acc (
    .clk  (pixel_clk_in),
    .rst  (rst_in),
    .clear(acc_clear),
    .load (acc_load),
    .inc  (ovl_p0_q),
    .count(acc)
  );

  assign hit_now = (acc >= TH);

  // FSM state register
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping enable wins over every other event
  always_comb begin
    state_d = state_q;
    if (!enable_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (start_p0_q) state_d = ACCUM;
        ACCUM:   if (end_p0_q) state_d = EVAL;
        EVAL:    state_d = hit_now ? HIT : ARMED;
        HIT:     if (clear_in) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: accumulator control and next values of the result registers
  always_comb begin
    acc_load     = enable_in && start_p0_q &&
                   ((state_q == ARMED) || (state_q == ACCUM));
    acc_clear    = !enable_in || ((state_q != ACCUM) && !acc_load);
    collision_d  = collision_q;
    hit_pulse_d  = 1'b0;
    frame_done_d = 1'b0;
    count_d      = count_q;
    if (!enable_in) begin
      collision_d = 1'b0;
    end else if (state_q == EVAL) begin
      count_d      = acc;
      frame_done_d = 1'b1;
      if (hit_now) begin
        collision_d = 1'b1;
        hit_pulse_d = 1'b1;
      end
    end else if ((state_q == HIT) && clear_in) begin
      collision_d = 1'b0;
    end
  end

  // Stage p1: registered results presented to the game FSM
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      collision_q  <= 1'b0;
      hit_pulse_q  <= 1'b0;
      frame_done_q <= 1'b0;
      count_q      <= '0;
    end else begin
      collision_q  <= collision_d;
      hit_pulse_q  <= hit_pulse_d;
      frame_done_q <= frame_done_d;
      count_q      <= count_d;
    end
  end

  assign collision_out     = collision_q;
  assign hit_pulse_out     = hit_pulse_q;
  assign frame_done_out    = frame_done_q;
  assign overlap_count_out = count_q;

endmodule
